// File: rtl/rle_pkg.sv
// rtl/rle_pkg.sv - shared RLE stream format definitions and decoder state encoding
package rle_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_EXPAND,
    ST_WR,
    ST_FLUSH,
    ST_FINISH
  } rle_state_e;

  localparam int PAIR_W         = 16;
  localparam int CNT_LSB        = 0;
  localparam int VAL_LSB        = 8;
  localparam int BYTES_PER_WORD = 4;

  // Pair 0 lives in the low half of a stream word, pair 1 in the high half.
  function automatic logic [PAIR_W-1:0] pair_of(input logic [31:0] word, input logic sel);
    return sel ? word[2*PAIR_W-1:PAIR_W] : word[PAIR_W-1:0];
  endfunction

endpackage

// File: rtl/rle_word_pack.sv
// rtl/rle_word_pack.sv - little-endian byte-to-word packer for the decoder output path
module rle_word_pack
  import rle_pkg::*;
(
  input  logic        clk,
  input  logic        nreset,
  input  logic        push_i,
  input  logic        clear_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        almost_full_o,
  output logic        pending_o
);

  logic [2:0]  cnt_q;
  logic [31:0] word_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (clear_i) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (push_i) begin
      word_q <= word_q | ({24'd0, byte_i} << {cnt_q[1:0], 3'b000});
      cnt_q  <= cnt_q + 3'd1;
    end
  end

  assign word_o        = word_q;
  assign almost_full_o = (cnt_q == 3'(BYTES_PER_WORD - 1));
  assign pending_o     = (cnt_q != 3'd0);

endmodule

// File: rtl/rle_decode.sv
// rtl/rle_decode.sv - RLE frame decompressor reading and writing one single-ported dpsram
module rle_decode
  import rle_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 32
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              start,
  input  logic [31:0]       rle_addr,
  input  logic [LEN_W-1:0]  rle_size,
  input  logic [31:0]       out_addr,
  output logic [LEN_W-1:0]  out_size,
  output logic              done,
  output logic              port_A_clk,
  output logic [ADDR_W-1:0] port_A_addr,
  output logic              port_A_we,
  output logic [31:0]       port_A_data_in,
  input  logic [31:0]       port_A_data_out
);

  rle_state_e        state_q, wr_next_q, route_d;
  logic [ADDR_W-1:0] rd_addr_q, wr_addr_q, addr_q;
  logic [LEN_W-1:0]  pairs_left_q, out_size_q;
  logic [7:0]        cnt_left_q, val_q;
  logic [PAIR_W-1:0] hi_pair_q, rd_lo, rd_hi;
  logic              pair_sel_q, we_q, done_q;
  logic              push, pair_done, filled, last_pair, pk_clear;
  logic              pk_almost_full, pk_pending;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{rle_addr[31:ADDR_W], out_addr[31:ADDR_W]};

  rle_word_pack u_pack (
    .clk           (clk),
    .nreset        (nreset),
    .push_i        (push),
    .clear_i       (pk_clear),
    .byte_i        (val_q),
    .word_o        (port_A_data_in),
    .almost_full_o (pk_almost_full),
    .pending_o     (pk_pending)
  );

  always_comb begin
    rd_lo     = pair_of(port_A_data_out, 1'b0);
    rd_hi     = pair_of(port_A_data_out, 1'b1);
    push      = (state_q == ST_EXPAND) && (cnt_left_q != 8'd0);
    pair_done = (state_q == ST_EXPAND) && (cnt_left_q <= 8'd1);
    filled    = push && pk_almost_full;
    last_pair = (pairs_left_q == LEN_W'(1));
    pk_clear  = (state_q == ST_WR) || (state_q == ST_FLUSH) || ((state_q == ST_IDLE) && start);
    // Where to go once the current byte (if any) is emitted, ignoring a full buffer.
    route_d = ST_EXPAND;
    if (pair_done) begin
      if (last_pair)       route_d = ST_FINISH;
      else if (pair_sel_q) route_d = ST_RD_ADDR;
      else                 route_d = ST_EXPAND;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q      <= ST_IDLE;
      wr_next_q    <= ST_IDLE;
      rd_addr_q    <= '0;
      wr_addr_q    <= '0;
      addr_q       <= '0;
      pairs_left_q <= '0;
      out_size_q   <= '0;
      cnt_left_q   <= '0;
      val_q        <= '0;
      hi_pair_q    <= '0;
      pair_sel_q   <= 1'b0;
      we_q         <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            rd_addr_q    <= rle_addr[ADDR_W-1:0];
            wr_addr_q    <= out_addr[ADDR_W-1:0];
            pairs_left_q <= rle_size >> 1;
            out_size_q   <= '0;
            done_q       <= 1'b0;
            if (rle_size[LEN_W-1:1] == '0) begin
              state_q <= ST_FINISH;
            end else begin
              addr_q  <= rle_addr[ADDR_W-1:0];
              state_q <= ST_RD_ADDR;
            end
          end
        end
        ST_RD_ADDR: state_q <= ST_RD_DATA;
        ST_RD_DATA: begin
          cnt_left_q <= rd_lo[CNT_LSB +: 8];
          val_q      <= rd_lo[VAL_LSB +: 8];
          hi_pair_q  <= rd_hi;
          pair_sel_q <= 1'b0;
          rd_addr_q  <= rd_addr_q + ADDR_W'(BYTES_PER_WORD);
          state_q    <= ST_EXPAND;
        end
        ST_EXPAND: begin
          if (push) begin
            out_size_q <= out_size_q + LEN_W'(1);
            cnt_left_q <= cnt_left_q - 8'd1;
          end
          if (pair_done) pairs_left_q <= pairs_left_q - LEN_W'(1);
          if (pair_done && (route_d == ST_EXPAND)) begin
            pair_sel_q <= 1'b1;
            cnt_left_q <= hi_pair_q[CNT_LSB +: 8];
            val_q      <= hi_pair_q[VAL_LSB +: 8];
          end
          if (filled) begin
            wr_next_q <= route_d;
            addr_q    <= wr_addr_q;
            we_q      <= 1'b1;
            state_q   <= ST_WR;
          end else if ((route_d == ST_FINISH) && (push || pk_pending)) begin
            addr_q  <= wr_addr_q;
            we_q    <= 1'b1;
            state_q <= ST_FLUSH;
          end else begin
            if (route_d == ST_RD_ADDR) addr_q <= rd_addr_q;
            state_q <= route_d;
          end
        end
        ST_WR: begin
          we_q      <= 1'b0;
          wr_addr_q <= wr_addr_q + ADDR_W'(BYTES_PER_WORD);
          if (wr_next_q == ST_RD_ADDR) addr_q <= rd_addr_q;
          state_q   <= wr_next_q;
        end
        ST_FLUSH: begin
          we_q      <= 1'b0;
          wr_addr_q <= wr_addr_q + ADDR_W'(BYTES_PER_WORD);
          state_q   <= ST_FINISH;
        end
        ST_FINISH: begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign port_A_clk  = clk;
  assign port_A_addr = addr_q;
  assign port_A_we   = we_q;
  assign out_size    = out_size_q;
  assign done        = done_q;

endmodule

// File: tb/tb_rle_decode.sv
// tb/tb_rle_decode.sv - scoreboard bench for rle_decode against a dpsram model
module tb_rle_decode;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] rle_addr = '0;
  logic [31:0] rle_size = '0;
  logic [31:0] out_addr = '0;
  logic [31:0] out_size;
  logic        done;
  logic        port_A_clk;
  logic [15:0] port_A_addr;
  logic        port_A_we;
  logic [31:0] port_A_data_in;
  logic [31:0] port_A_data_out;

  logic [31:0] mem [0:16383];

  typedef struct packed {
    logic [15:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] frame_words[$];
  int          checks = 0;
  int          errors = 0;

  rle_decode #(.ADDR_W(16), .LEN_W(32)) dut (
    .clk             (clk),
    .nreset          (nreset),
    .start           (start),
    .rle_addr        (rle_addr),
    .rle_size        (rle_size),
    .out_addr        (out_addr),
    .out_size        (out_size),
    .done            (done),
    .port_A_clk      (port_A_clk),
    .port_A_addr     (port_A_addr),
    .port_A_we       (port_A_we),
    .port_A_data_in  (port_A_data_in),
    .port_A_data_out (port_A_data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) port_A_data_out <= mem[port_A_addr[15:2]];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference expansion of frame_words into expected write transactions.
  task automatic model(input logic [31:0] oa, input logic [31:0] size, output logic [31:0] nbytes);
    logic [7:0]  b[$];
    logic [31:0] w, d;
    logic [15:0] pr;
    int          np;
    np = int'(size >> 1);
    for (int p = 0; p < np; p++) begin
      w  = frame_words[p / 2];
      pr = (p % 2 == 1) ? w[31:16] : w[15:0];
      for (int c = 0; c < int'(pr[7:0]); c++) b.push_back(pr[15:8]);
    end
    nbytes = 32'(b.size());
    for (int i = 0; i < b.size(); i += 4) begin
      d = '0;
      for (int k = 0; k < 4; k++)
        if (i + k < b.size()) d[8*k +: 8] = b[i + k];
      exp_q.push_back(wr_t'{a: 16'(oa + 32'(i)), d: d});
    end
  endtask

  task automatic run_frame(input string name, input logic [31:0] ra, input logic [31:0] oa,
                           input logic [31:0] size, input int poke_at, input int abort_at);
    logic [31:0] exp_size;
    wr_t         e;
    bit          fin;
    for (int i = 0; i < frame_words.size(); i++) mem[(ra >> 2) + 32'(i)] = frame_words[i];
    exp_q.delete();
    model(oa, size, exp_size);
    @(negedge clk);
    start = 1'b1; rle_addr = ra; out_addr = oa; rle_size = size;
    @(negedge clk);
    start = 1'b0;
    check({name, "_done_clr"}, 64'(done), 64'd0);
    fin = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i == poke_at) begin
        start = 1'b1; rle_addr = 32'h3000; rle_size = 32'd8;
      end else begin
        start = 1'b0;
      end
      if (i == abort_at) begin
        nreset = 1'b0;
        #1;
        check({name, "_rst_we"}, 64'(port_A_we), 64'd0);
        check({name, "_rst_done"}, 64'(done), 64'd0);
        check({name, "_rst_size"}, 64'(out_size), 64'd0);
        check({name, "_rst_addr"}, 64'(port_A_addr), 64'd0);
        check({name, "_rst_data"}, 64'(port_A_data_in), 64'd0);
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          check({name, "_rst_hold_we"}, 64'(port_A_we), 64'd0);
        end
        nreset = 1'b1;
        exp_q.delete();
        return;
      end
      if (port_A_we) begin
        if (exp_q.size() == 0) begin
          check({name, "_extra_write"}, 64'd1, 64'(exp_q.size()));
        end else begin
          e = exp_q.pop_front();
          check({name, "_wr_addr"}, 64'(port_A_addr), 64'(e.a));
          check({name, "_wr_data"}, 64'(port_A_data_in), 64'(e.d));
        end
      end
      if (done) begin
        fin = 1'b1;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({name, "_finished"}, 64'(fin), 64'd1);
    check({name, "_out_size"}, 64'(out_size), 64'(exp_size));
    check({name, "_writes_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    nreset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_done", 64'(done), 64'd0);
    check("reset_we", 64'(port_A_we), 64'd0);
    check("reset_out_size", 64'(out_size), 64'd0);
    check("reset_addr", 64'(port_A_addr), 64'd0);
    check("reset_data", 64'(port_A_data_in), 64'd0);
    nreset = 1'b1;
    @(negedge clk);

    // 3 x 0x42 then 2 x 0x41 -> 0x41424242, 0x00000041.
    frame_words = '{32'h4102_4203};
    run_frame("basic", 32'h0100, 32'h0800, 32'd4, -1, -1);

    frame_words.delete();
    run_frame("empty", 32'h0100, 32'h0900, 32'd0, -1, -1);

    frame_words = '{32'h3305_5500};
    run_frame("zero_cnt", 32'h0200, 32'h0A00, 32'd4, -1, -1);

    frame_words = '{32'h1234_AAFF};
    run_frame("cnt255", 32'h0300, 32'h0B00, 32'd2, 10, -1);

    frame_words = '{32'h9901_4C03};
    run_frame("odd_size", 32'h0400, 32'h0C00, 32'd3, -1, -1);

    frame_words.delete();
    for (int i = 0; i < 5; i++)
      frame_words.push_back({8'($urandom_range(0, 255)), 8'($urandom_range(0, 9)),
                             8'($urandom_range(0, 255)), 8'($urandom_range(0, 9))});
    run_frame("rand", 32'h0500, 32'h1000, 32'd20, -1, -1);

    frame_words.delete();
    for (int i = 0; i < 3; i++)
      frame_words.push_back({8'($urandom_range(0, 255)), 8'($urandom_range(0, 7)),
                             8'($urandom_range(0, 255)), 8'($urandom_range(0, 7))});
    run_frame("rand_odd", 32'h0600, 32'h1400, 32'd11, -1, -1);

    frame_words = '{32'h1234_AAFF};
    run_frame("abort", 32'h0300, 32'h1800, 32'd2, -1, 20);

    frame_words = '{32'h4102_4203};
    run_frame("after_rst", 32'h0700, 32'h1C00, 32'd4, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
